gcd_multi_processor: RTL and testbench
======================================

Name: gcd_multi_processor

Overview:
Parametrised successor to the two-operand GCD microprocessor (combined control unit plus datapath). It accepts NUM_OPERANDS values of WIDTH bits, one per rising edge of the operator `enter` key, and folds them into a running GCD using subtractive Euclid, one step per clock. It raises Halt with the result on dataOut and can restart from HALT without a reset. It sits at board top level between the switch/key inputs and the 7-segment/LED outputs.

Parameters:
WIDTH, 8, operand and result width in bits (2..32)
NUM_OPERANDS, 2, operands per computation (2..16)
CNT_W, $clog2(NUM_OPERANDS+1), width of opCount (derived, not overridable)

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
enter  input  1  operand-ready level from key, may stay high many cycles
dataIn  input  WIDTH  operand value, sampled on the enter rising-edge cycle
Halt  output  1  high while result is valid (HALT state)
IR  output  3  current state code (debug/LED)
dataOut  output  WIDTH  GCD result, registered
opCount  output  CNT_W  number of operands captured so far in this computation

Behaviour:
- Reset (reset=0, async) sets state=S_WAIT_A, A=0, B=0, dataOut=0, opCount=0, Halt=0, enter_q=1. enter_q=1 means an enter held high through reset release does not produce a capture.
- Edge detect: enter_q <= enter each clock; enter_rise = enter & ~enter_q. Only enter_rise acts.
- State codes on IR: S_WAIT_A=3'd0, S_WAIT_B=3'd1, S_COMPUTE=3'd2, S_HALT=3'd4. Unused codes go to S_WAIT_A on the next clock.
- S_WAIT_A: on enter_rise, A<=dataIn, opCount<=1, go to S_WAIT_B.
- S_WAIT_B: on enter_rise, B<=dataIn, opCount<=opCount+1, go to S_COMPUTE.
- S_COMPUTE, evaluated once per clock in this priority order:
  - B==0: finish, A unchanged.
  - A==0: A<=B, finish.
  - A==B: finish.
  - A>B: A<=A-B.
  - else: B<=B-A.
- Finish from S_COMPUTE:
  - If opCount==NUM_OPERANDS: dataOut<=final A, Halt<=1, go to S_HALT.
  - Otherwise go to S_WAIT_B; A holds the running GCD.
- Latency: k subtraction cycles plus 1 finish cycle after the B capture. Halt rises on the same clock edge that dataOut is written.
- enter edges that arrive during S_COMPUTE are discarded, not queued.
- Subtraction is unsigned WIDTH bits and never underflows, because the larger operand is always the minuend.
- Zero operands: gcd(x,0)=x and gcd(0,0)=0. A zero in any position is legal.
- S_HALT: dataOut and Halt are held. On enter_rise:
  - A<=dataIn, opCount<=1, Halt<=0, go to S_WAIT_B.
  - This is a restart; dataOut keeps the old result until the next HALT.
- Reset asserted mid-operation: immediate return to reset values; the partial computation is lost.
- Outputs are registered only; no combinational path from inputs to outputs.

Decomposition:
- Package gcd_pkg holds:
  - the state code localparams (S_WAIT_A, S_WAIT_B, S_COMPUTE, S_HALT);
  - the IR width constant (3).
- One sub-module, gcd_datapath: holds the A/B registers, the compare (eq, gt, a_zero, b_zero) and the subtractors. It is driven by load_a, load_b and step strobes from the FSM in the top.
- Edge detect and opCount stay in the top.

Test Plan:
1. Reset with enter=1 held, then release reset -> IR=0, opCount=0, no capture until enter drops and rises again.
2. NUM_OPERANDS=2, inputs 48 then 18 -> 4 subtraction cycles plus 1; Halt=1 and dataOut=6 exactly 5 clocks after the B-capture clock.
3. NUM_OPERANDS=2, inputs 51 then 22 -> Halt=1, dataOut=1 after 12 compute clocks; IR sequence 0,1,2,...,4.
4. NUM_OPERANDS=3, inputs 48, 18, 27 -> intermediate return to S_WAIT_B with opCount=2; final dataOut=3.
5. Zero cases: (0,35) gives dataOut=35; (35,0) gives 35; (0,0) gives 0, each finishing in 1 compute cycle. WIDTH=16 with (65535,65535) gives 65535.
6. From S_HALT, apply enter_rise with dataIn=100, then 75 -> Halt drops on the first edge, then dataOut=25. Also: assert reset mid-S_COMPUTE -> immediate IR=0, dataOut=0, Halt=0.

Source files
------------

// File: rtl/gcd_pkg.sv
// Shared state codes and debug-bus width for the multi-operand GCD processor.
package gcd_pkg;
  localparam int unsigned IR_W = 3;

  typedef enum logic [IR_W-1:0] {
    S_WAIT_A  = 3'd0,
    S_WAIT_B  = 3'd1,
    S_COMPUTE = 3'd2,
    S_HALT    = 3'd4
  } state_t;
endpackage

// File: rtl/gcd_multi_processor_if.sv
// Operator-side bundle: enter key and switches in, result, halt and debug state out.
interface gcd_multi_processor_if #(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned NUM_OPERANDS = 2
);
  localparam int unsigned CNT_W = $clog2(NUM_OPERANDS + 1);

  logic                     enter;
  logic [WIDTH-1:0]         dataIn;
  logic                     Halt;
  logic [gcd_pkg::IR_W-1:0] IR;
  logic [WIDTH-1:0]         dataOut;
  logic [CNT_W-1:0]         opCount;

  modport master (output enter, dataIn, input Halt, IR, dataOut, opCount);
  modport slave  (input enter, dataIn, output Halt, IR, dataOut, opCount);
endinterface

// File: rtl/gcd_datapath.sv
// A/B operand registers with compare flags and one subtractive-Euclid step per strobe.
module gcd_datapath #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_a,
  input  logic             load_b,
  input  logic             step,
  input  logic [WIDTH-1:0] din,
  output logic             eq,
  output logic             gt,
  output logic             a_zero,
  output logic             b_zero,
  output logic [WIDTH-1:0] result
);
  logic [WIDTH-1:0] a, b;

  assign eq     = (a == b);
  assign gt     = (a > b);
  assign a_zero = (a == '0);
  assign b_zero = (b == '0);
  // A zero A adopts B on its finishing step, so the result is B in that case.
  assign result = a_zero ? b : a;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      a <= '0;
      b <= '0;
    end else begin
      if (load_a)
        a <= din;
      else if (step && !b_zero && a_zero)
        a <= b;
      else if (step && !b_zero && !eq && gt)
        a <= a - b;

      if (load_b)
        b <= din;
      else if (step && !b_zero && !a_zero && !eq && !gt)
        b <= b - a;
    end
  end
endmodule

// File: rtl/gcd_multi_processor.sv
// Folds NUM_OPERANDS key-entered operands into a running GCD; halts with the result.
module gcd_multi_processor
  import gcd_pkg::*;
#(
  parameter int unsigned WIDTH        = 8,
  parameter int unsigned NUM_OPERANDS = 2
) (
  input logic                  clock,
  input logic                  reset,
  gcd_multi_processor_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(NUM_OPERANDS + 1);

  state_t           state, state_nx;
  logic             enter_q, enter_rise;
  logic [CNT_W-1:0] op_cnt;
  logic [WIDTH-1:0] data_out;
  logic             halt_q;
  logic             load_a, load_b, step, done, last;
  logic             eq, gt, a_zero, b_zero;
  logic [WIDTH-1:0] result;

  assign enter_rise = bus.enter & ~enter_q;
  assign last       = (op_cnt == CNT_W'(NUM_OPERANDS));

  gcd_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clock  (clock),
    .reset  (reset),
    .load_a (load_a),
    .load_b (load_b),
    .step   (step),
    .din    (bus.dataIn),
    .eq     (eq),
    .gt     (gt),
    .a_zero (a_zero),
    .b_zero (b_zero),
    .result (result)
  );

  always_comb begin
    state_nx = state;
    load_a   = 1'b0;
    load_b   = 1'b0;
    step     = 1'b0;
    done     = 1'b0;
    case (state)
      S_WAIT_A, S_HALT: begin
        if (enter_rise) begin
          load_a   = 1'b1;
          state_nx = S_WAIT_B;
        end
      end
      S_WAIT_B: begin
        if (enter_rise) begin
          load_b   = 1'b1;
          state_nx = S_COMPUTE;
        end
      end
      S_COMPUTE: begin
        // Step runs on the finishing cycle too so a zero A can take B.
        step = 1'b1;
        if (b_zero || a_zero || eq) begin
          done     = 1'b1;
          state_nx = last ? S_HALT : S_WAIT_B;
        end
      end
      default: state_nx = S_WAIT_A;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= S_WAIT_A;
      enter_q  <= 1'b1;
      op_cnt   <= '0;
      data_out <= '0;
      halt_q   <= 1'b0;
    end else begin
      state   <= state_nx;
      enter_q <= bus.enter;
      if (load_a)
        op_cnt <= CNT_W'(1);
      else if (load_b)
        op_cnt <= op_cnt + CNT_W'(1);
      if (done && last) begin
        data_out <= result;
        halt_q   <= 1'b1;
      end else if (load_a) begin
        halt_q <= 1'b0;
      end
    end
  end

  assign bus.IR      = state;
  assign bus.Halt    = halt_q;
  assign bus.dataOut = data_out;
  assign bus.opCount = op_cnt;
endmodule

// File: tb/tb_gcd_multi_processor.sv
// Directed and randomized checks of two processor configurations against a modulo-Euclid model.
module tb_gcd_multi_processor;
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  gcd_multi_processor_if #(.WIDTH(8),  .NUM_OPERANDS(2)) b8 ();
  gcd_multi_processor_if #(.WIDTH(16), .NUM_OPERANDS(3)) b16 ();

  gcd_multi_processor #(.WIDTH(8), .NUM_OPERANDS(2)) dut8 (
    .clock (clock),
    .reset (reset),
    .bus   (b8)
  );

  gcd_multi_processor #(.WIDTH(16), .NUM_OPERANDS(3)) dut16 (
    .clock (clock),
    .reset (reset),
    .bus   (b16)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int unsigned gcd_ref(input int unsigned x, input int unsigned y);
    int unsigned p, q, t;
    p = x;
    q = y;
    while (q != 0) begin
      t = p % q;
      p = q;
      q = t;
    end
    return p;
  endfunction

  task automatic press8(input int unsigned v);
    @(negedge clock);
    b8.dataIn = 8'(v);
    b8.enter  = 1'b1;
    @(negedge clock);
    b8.enter  = 1'b0;
  endtask

  task automatic press16(input int unsigned v);
    @(negedge clock);
    b16.dataIn = 16'(v);
    b16.enter  = 1'b1;
    @(negedge clock);
    b16.enter  = 1'b0;
  endtask

  // Counts clocks until Halt; ir_ok drops if IR leaves COMPUTE beforehand.
  task automatic wait_halt8(input int max, output int n, output bit ok, output bit ir_ok);
    n = 0; ok = 1'b0; ir_ok = 1'b1;
    while (n < max && !ok) begin
      @(negedge clock);
      n++;
      if (b8.Halt === 1'b1) ok = 1'b1;
      else if (b8.IR !== 3'd2) ir_ok = 1'b0;
    end
  endtask

  task automatic wait_halt16(input int max, output bit ok);
    int n;
    n = 0; ok = 1'b0;
    while (n < max && !ok) begin
      @(negedge clock);
      n++;
      if (b16.Halt === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic wait_wb16(input int max, output bit ok);
    int n;
    n = 0; ok = 1'b0;
    while (n < max && !ok) begin
      @(negedge clock);
      n++;
      if (b16.IR === 3'd1) ok = 1'b1;
    end
  endtask

  task automatic pair8(input string tag, input int unsigned x, input int unsigned y,
                       input int exp_lat);
    int  n;
    bit  ok, ir_ok;
    press8(x);
    press8(y);
    wait_halt8(600, n, ok, ir_ok);
    check({tag, "_halt_reached"}, 32'(ok), 32'd1);
    check({tag, "_dataOut"}, 32'(b8.dataOut), gcd_ref(x, y));
    check({tag, "_opCount"}, 32'(b8.opCount), 32'd2);
    if (exp_lat > 0) begin
      check({tag, "_latency"}, 32'(n), 32'(exp_lat));
      check({tag, "_ir_compute"}, 32'(ir_ok), 32'd1);
      check({tag, "_ir_halt"}, 32'(b8.IR), 32'd4);
    end
  endtask

  initial begin
    bit          ok;
    int unsigned x, y, z, g;

    b8.enter = 1'b1;  b8.dataIn = '0;
    b16.enter = 1'b0; b16.dataIn = '0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);

    // enter held through reset release must not capture
    check("rst_ir", 32'(b8.IR), 32'd0);
    check("rst_opCount", 32'(b8.opCount), 32'd0);
    check("rst_halt", 32'(b8.Halt), 32'd0);
    check("rst_dataOut", 32'(b8.dataOut), 32'd0);
    b8.enter = 1'b0;
    @(negedge clock);
    check("rst_no_capture", 32'(b8.IR), 32'd0);

    press8(48);
    check("cap_a_ir", 32'(b8.IR), 32'd1);
    check("cap_a_opCount", 32'(b8.opCount), 32'd1);
    press8(18);
    check("cap_b_ir", 32'(b8.IR), 32'd2);
    check("cap_b_opCount", 32'(b8.opCount), 32'd2);
    begin
      int n; bit ir_ok;
      wait_halt8(50, n, ok, ir_ok);
      check("g48_18_halt", 32'(ok), 32'd1);
      check("g48_18_latency", 32'(n), 32'd5);
      check("g48_18_ir_compute", 32'(ir_ok), 32'd1);
      check("g48_18_dataOut", 32'(b8.dataOut), 32'd6);
      check("g48_18_ir_halt", 32'(b8.IR), 32'd4);
    end

    // restart from HALT without reset; old result kept until next HALT
    press8(100);
    check("restart_halt_low", 32'(b8.Halt), 32'd0);
    check("restart_ir", 32'(b8.IR), 32'd1);
    check("restart_opCount", 32'(b8.opCount), 32'd1);
    check("restart_dataOut_kept", 32'(b8.dataOut), 32'd6);
    begin
      int n; bit ir_ok;
      press8(75);
      wait_halt8(50, n, ok, ir_ok);
      check("g100_75_halt", 32'(ok), 32'd1);
      check("g100_75_dataOut", 32'(b8.dataOut), 32'd25);
    end

    pair8("g51_22", 51, 22, 12);
    pair8("z0_35", 0, 35, 1);
    pair8("z35_0", 35, 0, 1);
    pair8("z0_0", 0, 0, 1);
    pair8("max255", 255, 255, 1);

    for (int unsigned i = 0; i < 24; i++) begin
      x = $urandom_range(0, 255);
      y = $urandom_range(0, 255);
      pair8("rand8", x, y, 0);
    end

    // three-operand fold; an edge during COMPUTE must be discarded
    press16(48);
    press16(18);
    press16(99);
    wait_wb16(100, ok);
    check("f3_mid_wait_b", 32'(ok), 32'd1);
    check("f3_mid_opCount", 32'(b16.opCount), 32'd2);
    check("f3_mid_halt", 32'(b16.Halt), 32'd0);
    press16(27);
    wait_halt16(100, ok);
    check("f3_halt", 32'(ok), 32'd1);
    check("f3_dataOut", 32'(b16.dataOut), 32'd3);
    check("f3_opCount", 32'(b16.opCount), 32'd3);

    press16(65535);
    press16(65535);
    wait_wb16(100, ok);
    check("w16_mid", 32'(ok), 32'd1);
    press16(65535);
    wait_halt16(100, ok);
    check("w16_halt", 32'(ok), 32'd1);
    check("w16_dataOut", 32'(b16.dataOut), 32'd65535);

    for (int unsigned i = 0; i < 8; i++) begin
      g = $urandom_range(1, 300);
      x = g * $urandom_range(0, 200);
      y = g * $urandom_range(0, 200);
      z = g * $urandom_range(0, 200);
      press16(x);
      press16(y);
      wait_wb16(1000, ok);
      check("rand16_mid", 32'(ok), 32'd1);
      press16(z);
      wait_halt16(1000, ok);
      check("rand16_halt", 32'(ok), 32'd1);
      check("rand16_dataOut", 32'(b16.dataOut), gcd_ref(gcd_ref(x, y), z));
    end

    // reset mid-COMPUTE returns to reset values immediately
    press8(100);
    press8(75);
    check("pre_rst_ir", 32'(b8.IR), 32'd2);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_ir", 32'(b8.IR), 32'd0);
    check("mid_rst_dataOut", 32'(b8.dataOut), 32'd0);
    check("mid_rst_halt", 32'(b8.Halt), 32'd0);
    check("mid_rst_opCount", 32'(b8.opCount), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
